seq369_checker: RTL and testbench

//  Receiver-side monitor for the 369 game counter stream (0,3,6,9,13,6,9,13,...).

---
 rtl/seq369_checker_if.sv | 22 ++
 rtl/seq369_checker.sv | 109 ++++++++++
 tb/tb_seq369_checker.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq369_checker_if.sv
// seq369_checker handshake bundle: sampled count in, lock/error status out.
interface seq369_checker_if #(
  parameter int ERR_W = 8
);
  logic             in_valid;
  logic [3:0]       in_count;
  logic             err_clr;
  logic             locked;
  logic             error;
  logic [3:0]       expected;
  logic [ERR_W-1:0] err_count;

  modport master (
    output in_valid, in_count, err_clr,
    input  locked, error, expected, err_count
  );

  modport slave (
    input  in_valid, in_count, err_clr,
    output locked, error, expected, err_count
  );
endinterface

// File: rtl/seq369_checker.sv
// seq369_checker: acquires and tracks the 0,3,6,9,13,6,... counter stream,
// locks after LOCK_LEN good samples and counts every deviation.
module seq369_checker #(
  parameter int LOCK_LEN = 3,
  parameter int ERR_W    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  seq369_checker_if.slave   bus
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [3:0]       run, run_nxt;
  logic [3:0]       exp_q, exp_nxt;
  logic [ERR_W-1:0] errc, errc_nxt;
  logic             err_q, err_nxt;
  logic [3:0]       succ, run_inc;
  logic             legal, match, miss;

  always_comb begin
    succ  = 4'd0;
    legal = 1'b1;
    unique case (bus.in_count)
      4'd0:    succ = 4'd3;
      4'd3:    succ = 4'd6;
      4'd6:    succ = 4'd9;
      4'd9:    succ = 4'd13;
      4'd13:   succ = 4'd6;
      default: legal = 1'b0;
    endcase
  end

  assign match   = (bus.in_count == exp_q);
  assign miss    = bus.in_valid && (state != HUNT) && !match;
  assign run_inc = run + 4'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= HUNT;
      run   <= 4'd0;
      exp_q <= 4'd0;
      errc  <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= run_nxt;
      exp_q <= exp_nxt;
      errc  <= errc_nxt;
      err_q <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    exp_nxt   = exp_q;
    err_nxt   = 1'b0;
    if (bus.in_valid) begin
      unique case (state)
        HUNT: begin
          if (legal) begin
            run_nxt   = 4'd1;
            exp_nxt   = succ;
            state_nxt = (LOCK_LEN == 1) ? LOCKED : SYNC;
          end
        end
        SYNC, LOCKED: begin
          if (match) begin
            exp_nxt = succ;
            if (state == SYNC) begin
              run_nxt = run_inc;
              if (run_inc == 4'(LOCK_LEN))
                state_nxt = LOCKED;
            end
          end else begin
            err_nxt   = 1'b1;
            state_nxt = HUNT;
            run_nxt   = 4'd0;
            exp_nxt   = 4'd0;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // Clear wins over a same-edge increment; the error pulse is unaffected.
  always_comb begin
    errc_nxt = errc;
    if (miss && (errc != {ERR_W{1'b1}}))
      errc_nxt = errc + 1'b1;
    if (bus.err_clr)
      errc_nxt = '0;
  end

  always_comb begin
    bus.locked    = (state == LOCKED);
    bus.error     = err_q;
    bus.expected  = exp_q;
    bus.err_count = errc;
  end

endmodule

// File: tb/tb_seq369_checker.sv
// Randomized and directed check of seq369_checker against a streak-based
// model, on two instances (LOCK_LEN=3/ERR_W=8 and LOCK_LEN=1/ERR_W=2).
module tb_seq369_checker;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  seq369_checker_if #(.ERR_W(8)) bus_a();
  seq369_checker_if #(.ERR_W(2)) bus_b();

  seq369_checker #(.LOCK_LEN(3), .ERR_W(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a)
  );
  seq369_checker #(.LOCK_LEN(1), .ERR_W(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b)
  );

  int checks = 0;
  int failures = 0;

  int lock_len[2] = '{3, 1};
  int err_max[2]  = '{255, 3};
  int nxt_tbl[16];

  bit m_hunt[2];
  int m_streak[2];
  int m_pred[2];
  int m_errs[2];
  bit m_pulse[2];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_hunt[k]   = 1'b1;
      m_streak[k] = 0;
      m_pred[k]   = 0;
      m_errs[k]   = 0;
      m_pulse[k]  = 1'b0;
    end
  endtask

  task automatic model_step(input bit v, input int c, input bit clr);
    for (int k = 0; k < 2; k++) begin
      m_pulse[k] = 1'b0;
      if (v) begin
        if (m_hunt[k]) begin
          if (nxt_tbl[c] >= 0) begin
            m_hunt[k]   = 1'b0;
            m_streak[k] = 1;
            m_pred[k]   = nxt_tbl[c];
          end
        end else if (c == m_pred[k]) begin
          m_streak[k]++;
          m_pred[k] = nxt_tbl[c];
        end else begin
          m_pulse[k]  = 1'b1;
          m_errs[k]++;
          m_hunt[k]   = 1'b1;
          m_streak[k] = 0;
        end
      end
      if (clr) m_errs[k] = 0;
    end
  endtask

  function automatic int m_locked(input int k);
    return (!m_hunt[k] && m_streak[k] >= lock_len[k]) ? 1 : 0;
  endfunction

  function automatic int m_expected(input int k);
    return m_hunt[k] ? 0 : m_pred[k];
  endfunction

  function automatic int m_errcnt(input int k);
    return (m_errs[k] > err_max[k]) ? err_max[k] : m_errs[k];
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_a_locked"}, int'(bus_a.locked),    m_locked(0));
    chk({tag, "_a_error"},  int'(bus_a.error),     int'(m_pulse[0]));
    chk({tag, "_a_exp"},    int'(bus_a.expected),  m_expected(0));
    chk({tag, "_a_errcnt"}, int'(bus_a.err_count), m_errcnt(0));
    chk({tag, "_b_locked"}, int'(bus_b.locked),    m_locked(1));
    chk({tag, "_b_error"},  int'(bus_b.error),     int'(m_pulse[1]));
    chk({tag, "_b_exp"},    int'(bus_b.expected),  m_expected(1));
    chk({tag, "_b_errcnt"}, int'(bus_b.err_count), m_errcnt(1));
  endtask

  task automatic drive(input bit v, input int c, input bit clr);
    bus_a.in_valid = v;
    bus_a.in_count = 4'(c);
    bus_a.err_clr  = clr;
    bus_b.in_valid = v;
    bus_b.in_count = 4'(c);
    bus_b.err_clr  = clr;
  endtask

  task automatic cyc(input string tag, input bit v, input int c,
                     input bit clr);
    drive(v, c, clr);
    @(posedge clk);
    model_step(v, c, clr);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    drive(1'b0, 0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  int seq1[7] = '{0, 3, 6, 9, 13, 6, 9};
  int legal_v[5] = '{0, 3, 6, 9, 13};

  initial begin
    for (int i = 0; i < 16; i++) nxt_tbl[i] = -1;
    nxt_tbl[0] = 3; nxt_tbl[3] = 6; nxt_tbl[6] = 9;
    nxt_tbl[9] = 13; nxt_tbl[13] = 6;
    model_reset();
    drive(1'b0, 0, 1'b0);
    #1;
    check_all("rst");
    chk("rst_a_exp0", int'(bus_a.expected), 0);
    #12;
    reset_n = 1'b1;

    // T1: clean acquisition and lock on the third sample
    for (int i = 0; i < 7; i++) begin
      cyc("t1", 1'b1, seq1[i], 1'b0);
      if (i == 1) chk("t1_not_locked", int'(bus_a.locked), 0);
      if (i == 2) chk("t1_locked", int'(bus_a.locked), 1);
    end
    chk("t1_exp13", int'(bus_a.expected), 13);

    // T2: deviation while locked, then relock
    cyc("t2", 1'b1, 9, 1'b0);
    chk("t2_error", int'(bus_a.error), 1);
    chk("t2_errcnt", int'(bus_a.err_count), 1);
    chk("t2_unlock", int'(bus_a.locked), 0);
    cyc("t2_gap", 1'b0, 0, 1'b0);
    chk("t2_pulse_end", int'(bus_a.error), 0);
    cyc("t2", 1'b1, 13, 1'b0);
    cyc("t2", 1'b1, 6, 1'b0);
    chk("t2_sync", int'(bus_a.locked), 0);
    cyc("t2", 1'b1, 9, 1'b0);
    chk("t2_relock", int'(bus_a.locked), 1);

    // T3: illegal values ignored while hunting
    do_reset("t3_rst");
    cyc("t3", 1'b1, 5, 1'b0);
    cyc("t3", 1'b1, 7, 1'b0);
    chk("t3_noerr", int'(bus_a.error), 0);
    cyc("t3", 1'b1, 0, 1'b0);
    chk("t3_exp3", int'(bus_a.expected), 3);

    // T4: gaps in in_valid
    cyc("t4", 1'b1, 3, 1'b0);
    cyc("t4", 1'b0, 11, 1'b0);
    cyc("t4", 1'b0, 2, 1'b0);
    chk("t4_hold", int'(bus_a.expected), 6);
    cyc("t4", 1'b1, 6, 1'b0);
    chk("t4_lock", int'(bus_a.locked), 1);

    // T5: saturation and clear-vs-mismatch
    do_reset("t5_rst");
    for (int i = 0; i < 4; i++) begin
      cyc("t5", 1'b1, 0, 1'b0);
      cyc("t5", 1'b1, 5, 1'b0);
    end
    chk("t5_sat", int'(bus_b.err_count), 3);
    cyc("t5", 1'b1, 0, 1'b0);
    cyc("t5_clr", 1'b1, 5, 1'b1);
    chk("t5_clr_cnt", int'(bus_b.err_count), 0);
    chk("t5_clr_err", int'(bus_b.error), 1);

    // T6: async reset while locked
    for (int i = 0; i < 4; i++) cyc("t6", 1'b1, seq1[i], 1'b0);
    chk("t6_locked", int'(bus_a.locked), 1);
    do_reset("t6_rst");
    chk("t6_rst_lock", int'(bus_a.locked), 0);
    cyc("t6", 1'b1, 6, 1'b0);
    chk("t6_exp9", int'(bus_a.expected), 9);
    chk("t6_sync", int'(bus_a.locked), 0);

    // Random stream biased toward the predicted value
    for (int n = 0; n < 3000; n++) begin
      bit v;
      bit clr;
      int c;
      int r;
      v = ($urandom_range(3, 0) != 0);
      r = $urandom_range(9, 0);
      if (r < 7 && !m_hunt[0]) c = m_pred[0];
      else if (r < 8) c = legal_v[$urandom_range(4, 0)];
      else c = $urandom_range(15, 0);
      clr = v && ($urandom_range(31, 0) == 0);
      cyc("rnd", v, c, clr);
      if (n % 700 == 699) do_reset("rnd_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
